// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the bus-processor control unit: opcodes, FSM states and ALU functions.
package proc_ctrl_pkg;

    localparam logic [2:0] OP_MVI  = 3'b000;
    localparam logic [2:0] OP_MV   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_T1   = 3'b001,
        ST_T2   = 3'b010,
        ST_T3   = 3'b011
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    function automatic logic [2:0] alu_func(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_ctrl_onehot.sv
// Index to one-hot decoder; output is all-zero when disabled or when the index has no register.
module proc_ctrl_onehot #(
    parameter int NREG = 8
) (
    input  logic            en,
    input  logic [3:0]      idx,
    output logic [NREG-1:0] oh
);

    localparam int IDXW = (NREG > 2) ? $clog2(NREG) : 1;

    logic in_range;

    always_comb begin
        // Any set bit above the index field means the register cannot exist.
        in_range = en && ((idx >> IDXW) == 4'd0);
        for (int i = 0; i < NREG; i++) begin
            oh[i] = in_range && (idx[IDXW-1:0] == IDXW'(i));
        end
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit: latches one instruction per run strobe and sequences bus enables over 1-3 steps.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [2:0]      op,
    input  logic [3:0]      rx,
    input  logic [3:0]      ry,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            din_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic [2:0]      alu_op,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2:0]      state
);

    localparam logic [4:0] NREG_W = 5'(NREG);

    state_t     state_r, state_nxt;
    logic [2:0] op_r;
    logic [3:0] rx_r, ry_r;
    logic       illegal;
    logic       in_en, out_en;
    logic [3:0] out_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_MVI;
            rx_r    <= '0;
            ry_r    <= '0;
        end else begin
            state_r <= state_nxt;
            if (state_r == ST_IDLE && run) begin
                op_r <= op;
                rx_r <= rx;
                ry_r <= ry;
            end
        end
    end

    // MVI carries no source register, so ry is only range-checked for the other ops.
    assign illegal = (op_r == OP_RSVD) ||
                     ({1'b0, rx_r} >= NREG_W) ||
                     ((op_r != OP_MVI) && ({1'b0, ry_r} >= NREG_W));

    always_comb begin
        state_nxt = state_r;
        in_en     = 1'b0;
        out_en    = 1'b0;
        out_idx   = rx_r;
        din_out   = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        alu_op    = ALU_ADD;
        done      = 1'b0;
        err       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nxt = ST_T1;
            end
            ST_T1: begin
                if (illegal) begin
                    done      = 1'b1;
                    err       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (op_r == OP_MVI) begin
                    din_out   = 1'b1;
                    in_en     = 1'b1;
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (op_r == OP_MV) begin
                    out_en    = 1'b1;
                    out_idx   = ry_r;
                    in_en     = 1'b1;
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    out_en    = 1'b1;
                    a_in      = 1'b1;
                    state_nxt = ST_T2;
                end
            end
            ST_T2: begin
                out_en    = 1'b1;
                out_idx   = ry_r;
                g_in      = 1'b1;
                alu_op    = alu_func(op_r);
                state_nxt = ST_T3;
            end
            ST_T3: begin
                g_out     = 1'b1;
                in_en     = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy  = (state_r != ST_IDLE);
    assign state = state_r;

    proc_ctrl_onehot #(.NREG(NREG)) u_reg_in (
        .en  (in_en),
        .idx (rx_r),
        .oh  (reg_in)
    );

    proc_ctrl_onehot #(.NREG(NREG)) u_reg_out (
        .en  (out_en),
        .idx (out_idx),
        .oh  (reg_out)
    );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: an NREG=8 and an NREG=4 instance share op/rx/ry, each with its own run.
module tb_proc_ctrl_fsm;
    import proc_ctrl_pkg::*;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       din;
        logic       a;
        logic       gi;
        logic       go;
        logic [2:0] alu;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run8 = 1'b0, run4 = 1'b0;
    logic [2:0] op = 3'b000;
    logic [3:0] rx = 4'd0, ry = 4'd0;

    logic [7:0] reg_in8, reg_out8;
    logic       din8, a8, gi8, go8, busy8, done8, err8;
    logic [2:0] alu8, st8;
    logic [3:0] reg_in4, reg_out4;
    logic       din4, a4, gi4, go4, busy4, done4, err4;
    logic [2:0] alu4, st4;

    obs_t o8, o4;
    obs_t q8[$];
    obs_t q4[$];
    int   n_chk = 0, n_fail = 0;
    int   done_cnt8 = 0, exp_done8 = 0;
    bit   mon_en = 1'b0;
    bit   pd[2];
    int   nsteps;
    logic [2:0] r_op;
    logic [3:0] r_rx, r_ry;

    always #5 clk = ~clk;

    proc_ctrl_fsm #(.NREG(8)) dut8 (
        .clk(clk), .reset(reset), .run(run8), .op(op), .rx(rx), .ry(ry),
        .reg_in(reg_in8), .reg_out(reg_out8), .din_out(din8), .a_in(a8),
        .g_in(gi8), .g_out(go8), .alu_op(alu8), .busy(busy8), .done(done8),
        .err(err8), .state(st8)
    );

    proc_ctrl_fsm #(.NREG(4)) dut4 (
        .clk(clk), .reset(reset), .run(run4), .op(op), .rx(rx), .ry(ry),
        .reg_in(reg_in4), .reg_out(reg_out4), .din_out(din4), .a_in(a4),
        .g_in(gi4), .g_out(go4), .alu_op(alu4), .busy(busy4), .done(done4),
        .err(err4), .state(st4)
    );

    assign o8 = {reg_in8, reg_out8, din8, a8, gi8, go8, alu8, busy8, done8, err8, st8};
    assign o4 = {4'b0, reg_in4, 4'b0, reg_out4, din4, a4, gi4, go4, alu4, busy4, done4, err4, st4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-step outputs of one instruction, written from the instruction table.
    task automatic push_expect(input bit d4, input logic [2:0] o, input logic [3:0] x,
                               input logic [3:0] y, output int n);
        int   nr;
        bit   ill;
        obs_t e;
        nr  = d4 ? 4 : 8;
        ill = (o == 3'b111) || (int'(x) >= nr) || ((o != 3'b000) && (int'(y) >= nr));
        e = '0; e.busy = 1'b1; e.st = 3'b001;
        if (ill) begin
            e.done = 1'b1; e.err = 1'b1; n = 1;
        end else if (o == 3'b000) begin
            e.din = 1'b1; e.rin = 8'b1 << x; e.done = 1'b1; n = 1;
        end else if (o == 3'b001) begin
            e.rout = 8'b1 << y; e.rin = 8'b1 << x; e.done = 1'b1; n = 1;
        end else begin
            e.rout = 8'b1 << x; e.a = 1'b1; n = 3;
        end
        if (d4) q4.push_back(e); else q8.push_back(e);
        if (n == 3) begin
            e = '0; e.busy = 1'b1; e.st = 3'b010; e.rout = 8'b1 << y; e.gi = 1'b1;
            case (o)
                3'b010:  e.alu = 3'b000;
                3'b011:  e.alu = 3'b001;
                3'b100:  e.alu = 3'b010;
                3'b101:  e.alu = 3'b011;
                default: e.alu = 3'b100;
            endcase
            if (d4) q4.push_back(e); else q8.push_back(e);
            e = '0; e.busy = 1'b1; e.st = 3'b011; e.go = 1'b1; e.rin = 8'b1 << x; e.done = 1'b1;
            if (d4) q4.push_back(e); else q8.push_back(e);
        end
    endtask

    task automatic mon_one(input int d, input obs_t o);
        obs_t e;
        int   qs;
        qs = (d == 1) ? q4.size() : q8.size();
        if (o.busy === 1'b1) begin
            if (qs == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_busy nreg%0d: got state %0d, expected idle", (d == 1) ? 4 : 8, o.st);
            end else begin
                if (d == 1) e = q4.pop_front(); else e = q8.pop_front();
                chk((d == 1) ? "step_nreg4" : "step_nreg8", 32'(o), 32'(e));
            end
        end else begin
            chk((d == 1) ? "idle_nreg4" : "idle_nreg8", 32'(o), 32'd0);
        end
        chk("single_bus_driver", 32'($countones({o.rout, o.din, o.go}) <= 1), 32'd1);
        chk("reg_in_onehot0", 32'($onehot0(o.rin)), 32'd1);
        chk("done_single_cycle", 32'(pd[d] && o.done), 32'd0);
        pd[d] = o.done;
        if (d == 0 && o.done === 1'b1) done_cnt8++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0, o8);
            mon_one(1, o4);
        end
    end

    task automatic issue(input bit d4, input logic [2:0] o, input logic [3:0] x,
                         input logic [3:0] y, input bit stray);
        int n;
        push_expect(d4, o, x, y, n);
        if (!d4) exp_done8++;
        op = o; rx = x; ry = y;
        if (d4) run4 = 1'b1; else run8 = 1'b1;
        tick();
        run4 = 1'b0; run8 = 1'b0;
        op = 3'($urandom); rx = 4'($urandom); ry = 4'($urandom);
        for (int k = 1; k < n; k++) begin
            if (stray && k == 2 && !d4) run8 = 1'b1;
            tick();
            run8 = 1'b0;
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        mon_en = 1'b1;
        tick();
        chk("reset_state", 32'(st8), 32'd0);
        chk("reset_outputs", 32'(o8), 32'd0);
        reset = 1'b0;

        // MVI r2
        push_expect(0, OP_MVI, 4'd2, 4'd0, nsteps);
        exp_done8++;
        op = OP_MVI; rx = 4'd2; ry = 4'd0; run8 = 1'b1;
        tick();
        run8 = 1'b0;
        chk("mvi_din_out", 32'(din8), 32'd1);
        chk("mvi_reg_in", 32'(reg_in8), 32'h04);
        chk("mvi_done", 32'(done8), 32'd1);
        chk("mvi_busy", 32'(busy8), 32'd1);
        tick();
        chk("mvi_after_state", 32'(st8), 32'd0);
        chk("mvi_after_outputs", 32'(o8), 32'd0);

        // MV r5,r1 with run held through T1, IDLE, T1: accepted twice
        push_expect(0, OP_MV, 4'd5, 4'd1, nsteps);
        push_expect(0, OP_MV, 4'd5, 4'd1, nsteps);
        exp_done8 += 2;
        op = OP_MV; rx = 4'd5; ry = 4'd1; run8 = 1'b1;
        tick();
        chk("mv_reg_out", 32'(reg_out8), 32'h02);
        chk("mv_reg_in", 32'(reg_in8), 32'h20);
        chk("mv_done", 32'(done8), 32'd1);
        tick();
        chk("mv_idle_gap_state", 32'(st8), 32'd0);
        tick();
        chk("mv_reaccept_state", 32'(st8), 32'd1);
        tick();
        run8 = 1'b0;
        chk("mv_back_idle", 32'(st8), 32'd0);

        // SUB r3,r6 with live inputs changed once accepted
        push_expect(0, OP_SUB, 4'd3, 4'd6, nsteps);
        exp_done8++;
        op = OP_SUB; rx = 4'd3; ry = 4'd6; run8 = 1'b1;
        tick();
        run8 = 1'b0; op = OP_OR; rx = 4'd0; ry = 4'd7;
        chk("sub_t1_reg_out", 32'(reg_out8), 32'h08);
        chk("sub_t1_a_in", 32'(a8), 32'd1);
        tick();
        chk("sub_t2_reg_out", 32'(reg_out8), 32'h40);
        chk("sub_t2_g_in", 32'(gi8), 32'd1);
        chk("sub_t2_alu_op", 32'(alu8), 32'd1);
        tick();
        chk("sub_t3_g_out", 32'(go8), 32'd1);
        chk("sub_t3_reg_in", 32'(reg_in8), 32'h08);
        chk("sub_t3_done", 32'(done8), 32'd1);
        tick();

        // NREG=4: ADD r5,r0 is out of range
        push_expect(1, OP_ADD, 4'd5, 4'd0, nsteps);
        op = OP_ADD; rx = 4'd5; ry = 4'd0; run4 = 1'b1;
        tick();
        run4 = 1'b0;
        chk("ill_done", 32'(done4), 32'd1);
        chk("ill_err", 32'(err4), 32'd1);
        chk("ill_reg_in", 32'(reg_in4), 32'd0);
        chk("ill_reg_out", 32'(reg_out4), 32'd0);
        tick();
        issue(1, OP_RSVD, 4'd0, 4'd0, 1'b0);
        issue(1, OP_MVI, 4'd4, 4'd0, 1'b0);
        issue(1, OP_MV, 4'd3, 4'd0, 1'b0);
        issue(1, OP_OR, 4'd0, 4'd3, 1'b0);
        issue(1, OP_XOR, 4'd2, 4'd4, 1'b0);
        issue(0, OP_MVI, 4'd7, 4'd15, 1'b0);
        issue(0, OP_ADD, 4'd3, 4'd3, 1'b0);
        issue(0, OP_AND, 4'd4, 4'd2, 1'b1);

        // XOR r1,r2 aborted by reset in T2
        push_expect(0, OP_XOR, 4'd1, 4'd2, nsteps);
        op = OP_XOR; rx = 4'd1; ry = 4'd2; run8 = 1'b1;
        tick();
        run8 = 1'b0;
        tick();
        chk("xor_in_t2", 32'(st8), 32'd2);
        reset = 1'b1;
        tick();
        void'(q8.pop_back());
        chk("abort_state", 32'(st8), 32'd0);
        chk("abort_outputs", 32'(o8), 32'd0);
        reset = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 2000; i++) begin
            r_op = 3'($urandom);
            r_rx = 4'($urandom_range(0, 9));
            r_ry = 4'($urandom_range(0, 9));
            issue(0, r_op, r_rx, r_ry, ($urandom % 4) == 0);
            if (($urandom % 3) == 0) tick();
        end

        tick();
        tick();
        chk("queue8_drained", 32'(q8.size()), 32'd0);
        chk("queue4_drained", 32'(q4.size()), 32'd0);
        chk("done_count", 32'(done_cnt8), 32'(exp_done8));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
